operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-file and operand-latch stage directly upstream of the 16-bit shifter and ALU in the lab datapath.
- Accepts a read request (Rn, Rm, shift code) and reads both registers through a single read port over two cycles.
- Latches them as operand A (to ALU) and operand B (to shifter), then presents A, B and the shift code downstream under a valid/ready handshake.
- Owns the writeback port for the 8x16 register file.

Parameters:
- DATA_W, 16, register and operand width
- NREG, 8, number of architectural registers
- REG_AW, 3, register index width (log2 NREG)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_rn  in  REG_AW  register index for operand A
- req_rm  in  REG_AW  register index for operand B
- req_shift  in  2  shift code forwarded to the shifter
- wr_en  in  1  writeback enable
- wr_num  in  REG_AW  writeback register index
- wr_data  in  DATA_W  writeback data
- out_valid  out  1  operands valid
- out_ready  in  1  downstream consumes when out_valid && out_ready
- out_a  out  DATA_W  latched operand A
- out_b  out  DATA_W  latched operand B (shifter input)
- out_shift  out  2  latched shift code

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE; all registers, out_a, out_b, out_shift = 0; out_valid=0.
- Reset mid-operation: the in-flight request is dropped with no output.
- FSM states: IDLE, RD_A, RD_B, VALID.
  - IDLE: req_ready=1. On accept, capture rn, rm and shift, then go to RD_A.
  - RD_A: A <= reg[rn], then go to RD_B.
  - RD_B: B <= reg[rm], then go to VALID.
  - VALID: out_valid=1.
    - out_ready=0: hold; out_a, out_b and out_shift stay stable.
    - out_ready=1 and req_valid=1: accept the new request and go to RD_A (req_ready = IDLE || (VALID && out_ready)).
    - out_ready=1 and req_valid=0: go to IDLE.
- Latency: request accepted at edge k; A latched at k+1; B latched at k+2; out_valid high from k+2.
- Throughput: one operation per 3 cycles back-to-back.
- req_ready and out_valid are never high in the same state without out_ready.
- Writeback:
  - When wr_en=1, reg[wr_num] <= wr_data on the rising edge, in any state.
  - Writes never stall.
- Read bypass:
  - In RD_A, if wr_en && wr_num==rn, A takes wr_data (not the stale value). Same rule for B in RD_B.
- Snapshot semantics: writes after an operand is latched do not change out_a or out_b.
- rn==rm is legal; both reads go through the port independently.
- out_shift is passed unchanged. The encoding is owned by the shared package:
  - 00 none
  - 01 left by 1
  - 10 logical right by 1
  - 11 arithmetic right by 1
- No arithmetic is performed here; all widths are exact DATA_W.
- Out-of-range indices cannot occur (REG_AW sized exactly).

Decomposition:
- Shared package holds:
  - constants DATA_W=16, REG_AW=3
  - shift-code constants SHIFT_NONE, SHIFT_LSL, SHIFT_LSR, SHIFT_ASR
  - FSM state encoding for IDLE, RD_A, RD_B, VALID
- One sub-module: regfile_8x16. It contains the storage, synchronous write port, async-reset clear and combinational single read mux with index select.
- operand_fetch holds the FSM, request capture, bypass compare and output registers.

Test Plan:
- Reset: assert reset mid-RD_B -> out_valid=0, out_a=out_b=0, req_ready=1 immediately. After release, all registers read 0.
- Basic fetch:
  - stimulus: write R2=16'h1234 and R5=16'hF00F; request rn=2, rm=5, shift=11
  - response: out_valid rises exactly 2 edges after accept, with out_a=1234, out_b=F00F, out_shift=11
- Bypass: request rn=3 while wr_en=1, wr_num=3, wr_data=16'hBEEF lands in the RD_A cycle -> out_a=BEEF. A write to R3 one cycle later (after A latched) leaves out_a=BEEF.
- Backpressure: hold out_ready=0 for 5 cycles in VALID while writing the source registers -> outputs stable and req_ready=0. Raising out_ready completes the transfer once.
- Back-to-back: req_valid held high with out_ready=1 -> a new accept on the same edge as each consume, one result every 3 cycles, values in request order.
- rn==rm=7 with R7=16'h8001 -> out_a=out_b=8001.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage and its register file.
//   DATA_W / NREG / REG_AW : operand width, register count, register index width
//   SHIFT_*                : shift codes carried through to the shifter
//   state_t                : operand fetch FSM state encoding
package operand_fetch_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    localparam logic [1:0] SHIFT_NONE = 2'b00;  // pass through
    localparam logic [1:0] SHIFT_LSL  = 2'b01;  // left by 1
    localparam logic [1:0] SHIFT_LSR  = 2'b10;  // logical right by 1
    localparam logic [1:0] SHIFT_ASR  = 2'b11;  // arithmetic right by 1

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_A  = 2'd1,
        ST_RD_B  = 2'd2,
        ST_VALID = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_8x16.sv
// 8 x 16 architectural register file with one write port and one read port.
//   clk, reset           : clock, asynchronous active-high clear of every register
//   i_wr_en/num/data     : synchronous write port, takes effect on the rising edge
//   i_rd_num, o_rd_data  : combinational read mux, returns the pre-edge contents
module regfile_8x16
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [REG_AW-1:0] i_wr_num,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [REG_AW-1:0] i_rd_num,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] w_regs [NREG];

    // One flop bank per register so each element has a single driver.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (i_wr_en && (i_wr_num == REG_AW'(gi))) begin
                    r_q <= i_wr_data;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign o_rd_data = w_regs[i_rd_num];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage feeding the shifter (operand B) and ALU (operand A).
// A request (rn, rm, shift) is read through the single register-file read
// port over two cycles, latched, and offered downstream with valid/ready.
//   clk, reset                    : clock, asynchronous active-high reset
//   req_valid/ready, req_rn/rm/shift : request handshake and register indices
//   wr_en/num/data                : register writeback, never stalls
//   out_valid/ready, out_a/b/shift   : latched operands and shift code
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_AW-1:0] req_rn,
    input  logic [REG_AW-1:0] req_rm,
    input  logic [1:0]        req_shift,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [1:0]        out_shift
);

    state_t            r_state;
    state_t            w_state_next;
    logic [REG_AW-1:0] r_rn;
    logic [REG_AW-1:0] r_rm;
    logic [1:0]        r_shift;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [1:0]        r_out_shift;

    logic              w_req_ready;
    logic              w_out_valid;
    logic              w_latch_a;
    logic              w_latch_b;
    logic              w_accept;
    logic [REG_AW-1:0] w_rd_num;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_rd_value;

    regfile_8x16 u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (wr_en),
        .i_wr_num  (wr_num),
        .i_wr_data (wr_data),
        .i_rd_num  (w_rd_num),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_out_valid  = 1'b0;
        w_latch_a    = 1'b0;
        w_latch_b    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = ST_RD_A;
                end
            end
            ST_RD_A: begin
                w_latch_a    = 1'b1;
                w_state_next = ST_RD_B;
            end
            ST_RD_B: begin
                w_latch_b    = 1'b1;
                w_state_next = ST_VALID;
            end
            ST_VALID: begin
                w_out_valid = 1'b1;
                // Consuming the result frees the stage, so a new request can
                // be taken on the same edge.
                if (out_ready) begin
                    w_req_ready  = 1'b1;
                    w_state_next = req_valid ? ST_RD_A : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept = w_req_ready && req_valid;

    // The read port serves rn in RD_A and rm in RD_B.
    assign w_rd_num = (r_state == ST_RD_B) ? r_rm : r_rn;

    // A write landing on the same edge as the operand latch must win over
    // the register contents, which still hold the old value this cycle.
    assign w_rd_value = (wr_en && (wr_num == w_rd_num)) ? wr_data : w_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rn        <= '0;
            r_rm        <= '0;
            r_shift     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_shift <= '0;
        end else begin
            if (w_accept) begin
                r_rn    <= req_rn;
                r_rm    <= req_rm;
                r_shift <= req_shift;
            end
            if (w_latch_a) begin
                r_a <= w_rd_value;
            end
            if (w_latch_b) begin
                r_b         <= w_rd_value;
                r_out_shift <= r_shift;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign out_valid = w_out_valid;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_shift = r_out_shift;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized scoreboard bench for operand_fetch. A reference model tracks
// register contents and the request pipeline at transaction level; a monitor
// on the falling edge compares the DUT outputs with the queued expectations.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sh;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_rn = '0;
    logic [2:0]  req_rm = '0;
    logic [1:0]  req_shift = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_num = '0;
    logic [15:0] wr_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [1:0]  out_shift;

    int n_vec = 0;
    int n_err = 0;

    operand_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .req_shift (req_shift),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_shift (out_shift)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_regs [8];
    exp_t        exp_q [$];
    int          m_phase = 0;   // 0: no fetch in flight, 1: A next, 2: B next
    logic [2:0]  m_rn, m_rm;
    logic [1:0]  m_sh;
    logic [15:0] m_a;
    bit          m_acc, m_cons;
    exp_t        m_e;

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < 8; i++) m_regs[i] = '0;
                exp_q.delete();
                m_phase = 0;
            end else begin
                m_cons = (exp_q.size() > 0) && out_ready;
                m_acc  = req_valid && (m_phase == 0) && ((exp_q.size() == 0) || out_ready);
                // A write on this edge is visible to an operand read on this edge.
                if (wr_en) m_regs[wr_num] = wr_data;
                if (m_cons) void'(exp_q.pop_front());
                if (m_phase == 2) begin
                    m_e.a  = m_a;
                    m_e.b  = m_regs[m_rm];
                    m_e.sh = m_sh;
                    exp_q.push_back(m_e);
                    m_phase = 0;
                end else if (m_phase == 1) begin
                    m_a = m_regs[m_rn];
                    m_phase = 2;
                end
                if (m_acc) begin
                    m_rn = req_rn;
                    m_rm = req_rm;
                    m_sh = req_shift;
                    m_phase = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
                chk("req_ready", 32'(req_ready),
                    32'((m_phase == 0) && ((exp_q.size() == 0) || out_ready)));
                if (out_valid && exp_q.size() > 0) begin
                    chk("out_a", 32'(out_a), 32'(exp_q[0].a));
                    chk("out_b", 32'(out_b), 32'(exp_q[0].b));
                    chk("out_shift", 32'(out_shift), 32'(exp_q[0].sh));
                    if (out_ready)
                        $display("xfer a=%h b=%h sh=%b", out_a, out_b, out_shift);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] n, input logic [15:0] d);
        wr_en = 1'b1; wr_num = n; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Returns 1ns after the accepting edge.
    task automatic do_req(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh);
        bit done;
        done = 0;
        req_valid = 1'b1; req_rn = rn; req_rm = rm; req_shift = sh;
        for (int i = 0; i < 50 && !done; i++) begin
            if (req_ready) done = 1;
            tick();
        end
        req_valid = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: rn=%0d rm=%0d not accepted", rn, rm);
        end
        $display("req rn=%0d rm=%0d sh=%b", rn, rm, sh);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() > 0 || m_phase != 0); i++) tick();
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_out_a", 32'(out_a), 32'd0);
        #20 reset = 1'b0;
        tick();

        // Basic fetch, held in VALID so the constants can be checked directly.
        out_ready = 1'b0;
        do_write(3'd2, 16'h1234);
        do_write(3'd5, 16'hF00F);
        do_req(3'd2, 3'd5, SHIFT_ASR);
        chk("lat_k1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_k2_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_k3_valid", 32'(out_valid), 32'd1);
        chk("basic_a", 32'(out_a), 32'h1234);
        chk("basic_b", 32'(out_b), 32'hF00F);
        chk("basic_shift", 32'(out_shift), 32'(SHIFT_ASR));
        drain();

        // Bypass: write R3 in the RD_A cycle, then again after A is latched.
        out_ready = 1'b0;
        do_req(3'd3, 3'd0, SHIFT_NONE);
        do_write(3'd3, 16'hBEEF);
        do_write(3'd3, 16'h1111);
        tick();
        chk("bypass_a", 32'(out_a), 32'hBEEF);
        drain();

        // Backpressure while overwriting both sources.
        out_ready = 1'b0;
        do_write(3'd1, 16'hAAAA);
        do_write(3'd4, 16'h5555);
        do_req(3'd1, 3'd4, SHIFT_LSR);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_num = (i % 2 == 0) ? 3'd1 : 3'd4; wr_data = 16'($urandom);
            tick();
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_a", 32'(out_a), 32'hAAAA);
            chk("bp_b", 32'(out_b), 32'h5555);
        end
        wr_en = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_once", 32'(out_valid), 32'd0);

        // rn == rm
        do_write(3'd7, 16'h8001);
        do_req(3'd7, 3'd7, SHIFT_LSL);
        tick(); tick();
        chk("same_a", 32'(out_a), 32'h8001);
        chk("same_b", 32'(out_b), 32'h8001);
        drain();

        // Back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) do_req(3'(i), 3'(7 - i), 2'(i));
        drain();

        // Reset in the middle of RD_B.
        do_req(3'd2, 3'd5, SHIFT_NONE);
        tick();
        #1 reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_a", 32'(out_a), 32'd0);
        chk("midrst_b", 32'(out_b), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        #4 reset = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) do_req(3'(i), 3'(i), SHIFT_NONE);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            wr_en     = ($urandom % 2) == 0;
            wr_num    = 3'($urandom);
            wr_data   = 16'($urandom);
            req_valid = ($urandom % 3) != 0;
            req_rn    = 3'($urandom);
            req_rm    = 3'($urandom);
            req_shift = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        req_valid = 1'b0;
        wr_en = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
